// File: rtl/axi_wr_arbiter_pkg.sv
// Shared write-arbiter definitions: FSM state encoding and default hold timeout.
package axi_wr_arbiter_pkg;

    localparam int unsigned AXI_WR_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi_wr_arbiter_rr_sel.sv
// Round-robin priority select: first set request at or after ptr, wrapping.
module rr_priority_sel #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic          done;
    logic [IW-1:0] pos;
    int            j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        done   = 1'b0;
        pos    = '0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            pos = IW'(j);
            if (!done && req[pos]) begin
                onehot[pos] = 1'b1;
                idx         = pos;
                done        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter giving one AXI master at a time ownership of the downstream
// write path from AW grant until B response, with a forced-release hold timeout.
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int NB_MASTER = 4,
    parameter int TIMEOUT   = AXI_WR_TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NB_MASTER-1:0]         req_i,
    output logic [NB_MASTER-1:0]         grant_o,
    output logic [$clog2(NB_MASTER)-1:0] grant_id_o,
    output logic                         busy_o,
    input  logic                         aw_hs_i,
    input  logic                         w_last_hs_i,
    input  logic                         b_hs_i,
    output logic                         timeout_o
);

    localparam int IW = $clog2(NB_MASTER);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    wr_state_e            state_q, state_d;
    logic [NB_MASTER-1:0] grant_q, grant_d;
    logic [IW-1:0]        id_q, id_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wl_q, wl_d;
    logic                 rel;

    logic [IW-1:0]        ptr;
    logic [NB_MASTER-1:0] sel_oh;
    logic [IW-1:0]        sel_idx;
    logic                 timeout_hit;

    assign ptr = (last_q == IW'(NB_MASTER - 1)) ? '0 : last_q + IW'(1);

    rr_priority_sel #(
        .N  (NB_MASTER),
        .IW (IW)
    ) u_sel (
        .req    (req_i),
        .ptr    (ptr),
        .onehot (sel_oh),
        .idx    (sel_idx)
    );

    assign timeout_hit = (state_q != ST_IDLE) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wl_d    = wl_q;
        rel     = 1'b0;
        if (state_q != ST_IDLE) cnt_d = cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_ADDR;
                    grant_d = sel_oh;
                    id_d    = sel_idx;
                    cnt_d   = '0;
                    wl_d    = 1'b0;
                end
            end
            ST_ADDR: begin
                // W may complete before AW; remember it so AW goes straight to RESP.
                if (aw_hs_i)             state_d = (w_last_hs_i || wl_q) ? ST_RESP : ST_DATA;
                else if (!req_i[id_q])   rel     = 1'b1;
                else if (w_last_hs_i)    wl_d    = 1'b1;
            end
            ST_DATA: if (w_last_hs_i) state_d = ST_RESP;
            ST_RESP: if (b_hs_i)      rel     = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) rel = 1'b1;
        if (rel) begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
            last_d  = id_q;
            cnt_d   = '0;
            wl_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= IW'(NB_MASTER - 1);
            cnt_q   <= '0;
            wl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wl_q    <= wl_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = id_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign timeout_o  = timeout_hit;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level ownership model.
module tb_axi_wr_arbiter;

    localparam int N  = 4;
    localparam int TO = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_id_o;
    logic         busy_o, aw_hs_i, w_last_hs_i, b_hs_i, timeout_o;

    int checks   = 0;
    int failures = 0;

    // model: owner (-1 = none), last owner, cycles held, which phases are done
    int m_owner, m_last, m_age;
    bit m_aw, m_wl;

    always #5 clk = ~clk;

    axi_wr_arbiter #(.NB_MASTER(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .aw_hs_i     (aw_hs_i),
        .w_last_hs_i (w_last_hs_i),
        .b_hs_i      (b_hs_i),
        .timeout_o   (timeout_o)
    );

    function automatic void model_reset();
        m_owner = -1; m_last = N - 1; m_age = 0; m_aw = 0; m_wl = 0;
    endfunction

    function automatic void model_release();
        m_last = m_owner; m_owner = -1; m_aw = 0; m_wl = 0; m_age = 0;
    endfunction

    function automatic void model_edge();
        bit rel, found;
        int c;
        rel = 0; found = 0;
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                c = (m_last + i) % N;
                if (!found && req_i[2'(c)]) begin
                    m_owner = c; found = 1;
                end
            end
            m_age = 0; m_aw = 0; m_wl = 0;
        end else if (m_age == TO) begin
            model_release();
        end else begin
            if (m_aw && m_wl)          rel = b_hs_i;
            else if (m_aw)             m_wl = m_wl | w_last_hs_i;
            else if (aw_hs_i)          begin m_aw = 1; m_wl = m_wl | w_last_hs_i; end
            else if (!req_i[2'(m_owner)]) rel = 1;
            else                       m_wl = m_wl | w_last_hs_i;
            if (rel) model_release();
            else     m_age++;
        end
    endfunction

    function automatic logic [N+3:0] exp_vec();
        logic [N-1:0] g;
        logic [1:0]   id;
        g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, id, (m_owner >= 0), (m_owner >= 0) && (m_age == TO)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic drive(input logic aw, input logic wl, input logic b);
        aw_hs_i = aw; w_last_hs_i = wl; b_hs_i = b;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; req_i = '0; drive(0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '0; drive(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
        checks++; if (grant_id_o !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", grant_id_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_i = 4'b0001;
        tick();
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", grant_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy_o); end
        drive(1, 0, 0); tick();
        req_i = '0; drive(0, 1, 0); tick();
        drive(0, 0, 1); tick();
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL single_release: got %b want 0000", grant_o); end
        checks++; if ({grant_o, grant_id_o, busy_o, timeout_o} !== exp_vec()) begin
            failures++; $display("FAIL single_model: got %b want %b", {grant_o, grant_id_o, busy_o, timeout_o}, exp_vec());
        end
        drive(0, 0, 0);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        reset_dut();
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = N'(1) << (k % N);
            tick();
            checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", k, grant_o, exp_g); end
            checks++; if (grant_id_o !== 2'(k % N)) begin failures++; $display("FAIL rr_id%0d: got %0d want %0d", k, grant_id_o, k % N); end
            drive(1, 0, 0); tick();
            drive(0, 1, 0); tick();
            drive(0, 0, 1); tick();
            drive(0, 0, 0);
            checks++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
                failures++; $display("FAIL rr_idle_gap%0d: got busy=%b grant=%b want busy=0 grant=0000", k, busy_o, grant_o);
            end
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_w_before_aw();
        reset_dut();
        req_i = 4'b0100;
        tick();
        checks++; if (grant_o !== 4'b0100 || grant_id_o !== 2'd2) begin
            failures++; $display("FAIL wfirst_grant: got %b/%0d want 0100/2", grant_o, grant_id_o);
        end
        drive(0, 1, 0); tick();
        drive(0, 0, 0); tick();
        checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL wfirst_hold: got %b want 0100", grant_o); end
        drive(1, 0, 0); tick();
        req_i = '0; drive(0, 0, 1); tick();
        drive(0, 0, 0);
        checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            failures++; $display("FAIL wfirst_skip_data: got grant=%b busy=%b want 0000/0", grant_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        int k;
        reset_dut();
        req_i = 4'b0001;
        tick();
        k = 0;
        drive(1, 1, 0); tick(); k++;
        req_i = '0; drive(0, 0, 0);
        while (timeout_o !== 1'b1 && k <= TO + 4) begin
            tick(); k++;
        end
        checks++; if (k !== TO) begin failures++; $display("FAIL timeout_cycles: got %0d want %0d", k, TO); end
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL timeout_grant_held: got %b want 0001", grant_o); end
        drive(0, 0, 1); tick();
        drive(0, 0, 0);
        checks++; if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin
            failures++; $display("FAIL timeout_release: got grant=%b timeout=%b want 0000/0", grant_o, timeout_o);
        end
    endtask

    task automatic test_withdraw();
        reset_dut();
        req_i = 4'b0010;
        tick();
        checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL withdraw_grant: got %b want 0010", grant_o); end
        req_i = '0; tick();
        checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            failures++; $display("FAIL withdraw_release: got grant=%b busy=%b want 0000/0", grant_o, busy_o);
        end
        req_i = 4'b1111; tick();
        checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL withdraw_next_rr: got %b want 0100", grant_o); end
        req_i = '0; tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req_i = 4'b0100;
        tick();
        drive(1, 0, 0); tick();
        drive(0, 0, 0); req_i = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            failures++; $display("FAIL async_reset_drop: got grant=%b busy=%b want 0000/0", grant_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1; req_i = 4'b1111;
        tick();
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL reset_first_prio: got %b want 0001", grant_o); end
        req_i = '0; tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req_i = N'($urandom_range(0, 15));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) drive(0, 0, 0);
            tick();
            checks++;
            if ({grant_o, grant_id_o, busy_o, timeout_o} !== exp_vec()) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL random_c%0d: got %b want %b (grant,id,busy,timeout)", c,
                                        {grant_o, grant_id_o, busy_o, timeout_o}, exp_vec());
            end
        end
        req_i = '0; drive(0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_w_before_aw();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
